activacion_pwl: RTL and testbench
=================================

# activacion_pwl

Pipelined piecewise-linear sigmoid evaluator sitting directly downstream of the 32-segment threshold comparator in the neuron datapath. For each accepted sample it takes the neuron's signed accumulator value `in_x` and the comparator's 5-bit segment index `in_seg`. It looks up that segment's slope/intercept pair in a runtime-loadable 32-entry coefficient table, computes `y = slope*x + intercept`, saturates the result to [0, 1) and presents it on a valid/ready output. Results feed the next layer's input buffer.

## Interface
- `Width`, 24: width of signed input `in_x`, fixed-point with `Frac` fractional bits.
- `Frac`, 16: fractional bits of `in_x`, of slope, of intercept and of `out_y`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_x`  in  Width  signed accumulator value.
- `in_seg`  in  5  segment index from the comparator (0..31).
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `cfg_we`  in  1  coefficient write strobe.
- `cfg_addr`  in  5  coefficient entry to write.
- `cfg_slope`  in  16  signed slope, Q0.16 fraction bits (two's complement).
- `cfg_icpt`  in  17  signed intercept, 16 fraction bits.
- `out_y`  out  16  unsigned activation, Q0.16 (0x0000..0xFFFF).
- `out_seg`  out  5  segment index carried with `out_y`.
- `out_valid`  out  1  `out_y`/`out_seg` valid.
- `out_ready`  in  1  consumer accepts output this cycle.

## Operation
- Coefficient table: 32 entries of {slope[15:0], icpt[16:0]}, register-based, all entries reset to 0.
  - `cfg_we` writes entry `cfg_addr` at the clock edge. Writes are legal at any time.
- Global advance enable `en = !out_valid || out_ready`; `in_ready = en`. A sample is accepted when `in_valid && in_ready`.
- Stage S1 (on accept): register `x`, `seg` and the table entry `tbl[in_seg]`, read before the write. A same-cycle write to the same address does not affect the accepted sample. Later writes never affect samples already in flight.
- Stage S2: `prod = x * slope`, signed, Width+16 bits, 2*Frac fraction bits. Register `p = prod >>> Frac` (arithmetic shift, truncation toward -inf) and the intercept.
- Stage S3: `sum = p + sign_extend(icpt)` at Width+17 bits, no overflow possible.
  - `sum < 0` → `out_y = 0x0000`.
  - `sum > 0xFFFF` → `out_y = 0xFFFF`.
  - Otherwise `out_y = sum[15:0]`.
- Each stage carries a valid bit. All stage registers advance only when `en`=1. Bubbles are not collapsed: the whole pipe stalls while the output is held.
- While `out_valid && !out_ready`: `out_y`, `out_seg` and `out_valid` hold stable, and `in_ready` = 0.
- `in_seg` is used as given. The block does not recheck it against `in_x`.

## Timing
- Reset values:
  - `out_y` = 0, `out_seg` = 0, `out_valid` = 0.
  - All stage valid bits = 0, all table entries = 0.
  - `in_ready` = 1 immediately, since `out_valid` = 0.
- Latency: a sample accepted at edge N appears with `out_valid` = 1 after edge N+3, given no stall.
- Throughput: 1 sample/cycle with `out_ready` held high.
- Stall: each cycle with `out_valid`=1 and `out_ready`=0 adds exactly one cycle to every in-flight sample. No sample is lost or duplicated.
- Reset asserted mid-operation: all in-flight samples are discarded and outputs go to their reset values asynchronously. The coefficient table is cleared, so the host reloads it after reset.
- A config write takes effect for samples accepted on the next edge or later.

## Test plan
- Reset, then load entry 5 with slope 0x4000 (0.25) and icpt 0x08000 (0.5). Send `in_x`=0x000000 with seg 5 → after 3 cycles `out_y`=0x8000, `out_seg`=5. Send `in_x`=0x010000 (1.0) → `out_y`=0xC000.
- Saturation with entry 5 as above: `in_x`=0x040000 (+4.0) → `out_y`=0xFFFF. `in_x`=0xFC0000 (-4.0) → `out_y`=0x0000.
- Streaming: 8 back-to-back samples with `out_ready`=1 → 8 consecutive `out_valid` cycles, in order, starting 3 cycles after the first accept.
- Backpressure: stream 6 samples, with `out_ready` low for 4 cycles mid-stream → `in_ready` low during the hold, outputs stable, all 6 results delivered in order with no duplicates.
- Config hazard: write entry 5 slope 0x0000, icpt 0x04000 in the same cycle a seg-5 sample `in_x`=0x010000 is accepted → that sample gives 0xC000 (old coefficients). The next seg-5 sample gives 0x4000.
- Reset mid-stream with 3 samples in flight → `out_valid` drops immediately and no stale result appears after reset release. A seg-5 sample after release returns 0x0000 (table cleared).

Source files
------------

// File: rtl/activacion_pwl_if.sv
// Stream and coefficient-load bundle for the piecewise-linear activation block.
// The slave view is the evaluator; the master view is whatever feeds it and
// consumes its results.
interface activacion_pwl_if #(
    parameter int Width = 24
);
    logic signed [Width-1:0] in_x;
    logic        [4:0]       in_seg;
    logic                    in_valid;
    logic                    in_ready;

    logic                    cfg_we;
    logic        [4:0]       cfg_addr;
    logic        [15:0]      cfg_slope;
    logic        [16:0]      cfg_icpt;

    logic        [15:0]      out_y;
    logic        [4:0]       out_seg;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_x, in_seg, in_valid, cfg_we, cfg_addr, cfg_slope, cfg_icpt, out_ready,
        output in_ready, out_y, out_seg, out_valid
    );

    modport master (
        output in_x, in_seg, in_valid, cfg_we, cfg_addr, cfg_slope, cfg_icpt, out_ready,
        input  in_ready, out_y, out_seg, out_valid
    );
endinterface

// File: rtl/activacion_pwl.sv
// Pipelined piecewise-linear sigmoid: y = slope[seg]*x + icpt[seg], clamped
// to [0, 1) in Q0.16. Four register ranks (capture, product, sum, output)
// so a sample accepted at edge N is presented after edge N+3. The whole pipe
// advances together and freezes while the output is held.
module activacion_pwl #(
    parameter int Width = 24,
    parameter int Frac  = 16
) (
    input  logic               clk,
    input  logic               rst,
    activacion_pwl_if.slave    bus
);
    localparam int PW = Width + 16;   // product / shifted product width
    localparam int SW = Width + 17;   // sum width, wide enough to never overflow

    // Coefficient table, one {slope, icpt} pair per segment.
    logic [15:0] slope_tbl [32];
    logic [16:0] icpt_tbl  [32];

    logic en;
    logic accept;

    logic                    s1_valid_reg;
    logic signed [Width-1:0] s1_x_reg;
    logic        [4:0]       s1_seg_reg;
    logic signed [15:0]      s1_slope_reg;
    logic signed [16:0]      s1_icpt_reg;

    logic                    s2_valid_reg;
    logic signed [PW-1:0]    s2_p_reg;
    logic signed [16:0]      s2_icpt_reg;
    logic        [4:0]       s2_seg_reg;

    logic                    s3_valid_reg;
    logic signed [SW-1:0]    s3_sum_reg;
    logic        [4:0]       s3_seg_reg;

    logic                    out_valid_reg;
    logic        [15:0]      out_y_reg;
    logic        [4:0]       out_seg_reg;

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    p_next;
    logic signed [SW-1:0]    sum_next;
    logic        [15:0]      sat_next;

    assign en           = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && en;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_y     = out_y_reg;
    assign bus.out_seg   = out_seg_reg;

    // Table writes; a read in the same cycle sees the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                slope_tbl[i] <= '0;
                icpt_tbl[i]  <= '0;
            end
        end else if (bus.cfg_we) begin
            slope_tbl[bus.cfg_addr] <= bus.cfg_slope;
            icpt_tbl[bus.cfg_addr]  <= bus.cfg_icpt;
        end
    end

    // S1: capture the sample together with its coefficients so later table
    // writes cannot reach it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
            s1_seg_reg   <= '0;
            s1_slope_reg <= '0;
            s1_icpt_reg  <= '0;
        end else if (en) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_x_reg     <= bus.in_x;
                s1_seg_reg   <= bus.in_seg;
                s1_slope_reg <= slope_tbl[bus.in_seg];
                s1_icpt_reg  <= icpt_tbl[bus.in_seg];
            end
        end
    end

    // Full-width signed product, rescaled to Frac fraction bits (floor).
    always_comb begin
        prod   = PW'(s1_x_reg) * PW'(s1_slope_reg);
        p_next = prod >>> Frac;
    end

    // S2: scaled product and the intercept it will be added to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_p_reg     <= '0;
            s2_icpt_reg  <= '0;
            s2_seg_reg   <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_p_reg     <= p_next;
            s2_icpt_reg  <= s1_icpt_reg;
            s2_seg_reg   <= s1_seg_reg;
        end
    end

    // Sign-extended sum; the extra bit guarantees no wraparound.
    always_comb begin
        sum_next = SW'(s2_p_reg) + SW'(s2_icpt_reg);
    end

    // S3: unsaturated sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_reg <= 1'b0;
            s3_sum_reg   <= '0;
            s3_seg_reg   <= '0;
        end else if (en) begin
            s3_valid_reg <= s2_valid_reg;
            s3_sum_reg   <= sum_next;
            s3_seg_reg   <= s2_seg_reg;
        end
    end

    // Clamp to [0, 0xFFFF]: negative -> 0, anything above 16 bits -> all ones.
    always_comb begin
        sat_next = s3_sum_reg[15:0];
        if (s3_sum_reg[SW-1]) begin
            sat_next = 16'h0000;
        end else if (|s3_sum_reg[SW-2:16]) begin
            sat_next = 16'hFFFF;
        end
    end

    // Output register; frozen while the consumer withholds out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_seg_reg   <= '0;
        end else if (en) begin
            out_valid_reg <= s3_valid_reg;
            if (s3_valid_reg) begin
                out_y_reg   <= sat_next;
                out_seg_reg <= s3_seg_reg;
            end
        end
    end
endmodule

// File: tb/tb_activacion_pwl.sv
// Directed bench for activacion_pwl: single-sample math and saturation,
// streaming, backpressure, config hazard and mid-stream reset.
module tb_activacion_pwl;
    logic clk;
    logic rst;

    activacion_pwl_if #(.Width(24)) bus ();

    activacion_pwl #(.Width(24), .Frac(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int passes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [15:0] slope, input logic [16:0] icpt);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_slope = slope;
        bus.cfg_icpt  = icpt;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // One isolated sample: accept, confirm 3-edge latency, check result.
    task automatic run_one(input string tag, input logic [23:0] x, input logic [4:0] seg,
                           input logic [15:0] exp_y);
        bus.in_x     = x;
        bus.in_seg   = seg;
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        tick();
        tick();
        check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_y"}, 32'(bus.out_y), 32'(exp_y));
        check({tag, "_seg"}, 32'(bus.out_seg), 32'(seg));
        $display("txn %s x=%h seg=%0d y=%h", tag, x, seg, bus.out_y);
        tick();
    endtask

    logic [15:0] exp_q [$];
    logic [15:0] held_y;
    logic        was_held;
    int          sent;
    int          recv;

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.in_x = '0; bus.in_seg = '0; bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_slope = '0; bus.cfg_icpt = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_y", 32'(bus.out_y), 32'd0);
        check("rst_out_seg", 32'(bus.out_seg), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Entry 5: 0.25*x + 0.5. Entry 7: -2^-16*x + 16*2^-16.
        cfg_write(5'd5, 16'h4000, 17'h08000);
        cfg_write(5'd7, 16'hFFFF, 17'h00010);

        run_one("x0",     24'h000000, 5'd5, 16'h8000);
        run_one("x1",     24'h010000, 5'd5, 16'hC000);
        run_one("sat_hi", 24'h040000, 5'd5, 16'hFFFF);
        run_one("sat_lo", 24'hFC0000, 5'd5, 16'h0000);
        run_one("edge1",  24'h020000, 5'd5, 16'hFFFF);   // sum exactly 0x10000
        run_one("floor",  24'h000001, 5'd7, 16'h000F);   // -1 >>> 16 = -1
        run_one("unused", 24'h010000, 5'd3, 16'h0000);   // untouched entry

        // Streaming: x = k*0x1000 -> y = 0x8000 + k*0x400, 8 back to back.
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.in_valid = (cyc < 8);
            bus.in_x     = 24'(cyc * 32'h1000);
            bus.in_seg   = 5'd5;
            tick();
            if (cyc >= 3 && cyc < 11) begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_y", 32'(bus.out_y), 32'h8000 + 32'((cyc - 3) * 32'h400));
                $display("txn stream idx=%0d y=%h", cyc - 3, bus.out_y);
            end else begin
                check("stream_idle", 32'(bus.out_valid), 32'd0);
            end
        end
        bus.in_valid = 1'b0;

        // Backpressure: 6 samples, out_ready low for loop cycles 4..7.
        sent = 0;
        recv = 0;
        was_held = 1'b0;
        held_y = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.in_valid  = (sent < 6);
            bus.in_x      = 24'(sent * 32'h2000);
            bus.in_seg    = 5'd5;
            bus.out_ready = !(cyc >= 4 && cyc <= 7);
            #1;
            if (was_held) begin
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_y", 32'(bus.out_y), 32'(held_y));
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                was_held = 1'b1;
                held_y = bus.out_y;
            end else begin
                was_held = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(16'(32'h8000 + sent * 32'h800));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra", 32'(bus.out_y), 32'hFFFF_FFFF);
                end else begin
                    check("bp_y", 32'(bus.out_y), 32'(exp_q.pop_front()));
                    $display("txn bp idx=%0d y=%h", recv, bus.out_y);
                    recv++;
                end
            end
            @(posedge clk);
            #0;
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_sent", 32'(sent), 32'd6);
        check("bp_recv", 32'(recv), 32'd6);
        tick();

        // Config hazard: same-cycle write must not affect the accepted sample.
        bus.cfg_we = 1'b1; bus.cfg_addr = 5'd5; bus.cfg_slope = 16'h0000; bus.cfg_icpt = 17'h04000;
        run_one("haz_old", 24'h010000, 5'd5, 16'hC000);
        run_one("haz_new", 24'h010000, 5'd5, 16'h4000);

        // Mid-stream reset with samples in flight.
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 24'h010000;
            bus.in_seg   = 5'd5;
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid_valid_pre", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid_async", 32'(bus.out_valid), 32'd0);
        check("mid_y_async", 32'(bus.out_y), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            check("mid_no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_one("cleared", 24'h010000, 5'd5, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
